// File: rtl/smc_obv_ctrl.sv
// Sliding-mode position controller feeding the SMC disturbance observer.
// One sample per tick is computed on a single time-shared 32x16 multiplier, then handed off via start/done.
//
// state    | meaning
// ---------+------------------------------------------------------
// S_IDLE   | waiting for tick; captures all inputs on tick
// S_ERR    | e = theta_ref - theta, de = dtheta_ref - dtheta
// S_MULC   | ce = (C*e) >>> 7
// S_SURF   | s = ce + de, ss = clamp(s, +-PHI)
// S_MULKS  | ts = (KS*ss) >>> 7
// S_MULKP  | tp = (KP*s) >>> 7
// S_SUM    | ur = ts + tp - dp
// S_CLAMP  | u = clamp(ur, +-UMAX), sat_flag
// S_START  | start strobe, observer latches u
// S_WAIT   | observer settle, OBS_LAT cycles
// S_DONE   | done strobe, observer commits
module smc_obv_ctrl #(
  parameter logic signed [15:0] C       = 16'sd50,
  parameter logic signed [15:0] KS      = 16'sd128,
  parameter logic signed [15:0] KP      = 16'sd64,
  parameter logic signed [31:0] PHI     = 32'sd256,
  parameter logic signed [31:0] UMAX    = 32'sd20000,
  parameter int                 OBS_LAT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stop_rst,
  input  logic               tick,
  input  logic signed [31:0] theta_ref,
  input  logic signed [31:0] theta,
  input  logic signed [31:0] dtheta_ref,
  input  logic signed [31:0] dtheta,
  input  logic signed [31:0] dp,
  output logic signed [31:0] u,
  output logic               start,
  output logic               done,
  output logic               busy,
  output logic               sat_flag,
  output logic               overrun
);

  localparam int CW = $clog2(OBS_LAT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ERR, S_MULC, S_SURF, S_MULKS, S_MULKP,
    S_SUM, S_CLAMP, S_START, S_WAIT, S_DONE
  } state_t;

  state_t state, state_nxt;
  logic [CW-1:0] wait_cnt;

  logic signed [31:0] cap_tr, cap_t, cap_dtr, cap_dt, cap_dp;
  logic signed [31:0] e, de, ce, s, ss, ts, tp, ur;

  logic signed [31:0] mul_a;
  logic signed [15:0] mul_b;
  logic signed [47:0] mul_p;
  logic signed [47:0] mul_sh;
  logic signed [31:0] mul_q;

  function automatic logic signed [47:0] ext32(input logic signed [31:0] x);
    return {{16{x[31]}}, x};
  endfunction

  function automatic logic signed [47:0] ext16(input logic signed [15:0] x);
    return {{32{x[15]}}, x};
  endfunction

  function automatic logic signed [31:0] sat48(input logic signed [47:0] x);
    if (x > 48'sd2147483647)
      return 32'sh7fffffff;
    else if (x < -48'sd2147483648)
      return 32'sh80000000;
    else
      return x[31:0];
  endfunction

  function automatic logic signed [31:0] sadd(input logic signed [31:0] a, input logic signed [31:0] b);
    return sat48(ext32(a) + ext32(b));
  endfunction

  function automatic logic signed [31:0] ssub(input logic signed [31:0] a, input logic signed [31:0] b);
    return sat48(ext32(a) - ext32(b));
  endfunction

  function automatic logic signed [31:0] clamp(input logic signed [31:0] x, input logic signed [31:0] lim);
    if (x > lim)
      return lim;
    else if (x < -lim)
      return -lim;
    else
      return x;
  endfunction

  // The only multiplier; operands are steered by the current state.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      S_MULC:  begin mul_a = e;  mul_b = C;  end
      S_MULKS: begin mul_a = ss; mul_b = KS; end
      S_MULKP: begin mul_a = s;  mul_b = KP; end
      default: ;
    endcase
  end

  assign mul_p  = ext32(mul_a) * ext16(mul_b);
  assign mul_sh = mul_p >>> 7;
  assign mul_q  = sat48(mul_sh);

  always_ff @(posedge clk) begin
    if (!rst_n || stop_rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:  if (tick) state_nxt = S_ERR;
      S_ERR:   state_nxt = S_MULC;
      S_MULC:  state_nxt = S_SURF;
      S_SURF:  state_nxt = S_MULKS;
      S_MULKS: state_nxt = S_MULKP;
      S_MULKP: state_nxt = S_SUM;
      S_SUM:   state_nxt = S_CLAMP;
      S_CLAMP: state_nxt = S_START;
      S_START: begin
        start     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT:  if (wait_cnt == '0) state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || stop_rst) begin
      cap_tr   <= '0;
      cap_t    <= '0;
      cap_dtr  <= '0;
      cap_dt   <= '0;
      cap_dp   <= '0;
      e        <= '0;
      de       <= '0;
      ce       <= '0;
      s        <= '0;
      ss       <= '0;
      ts       <= '0;
      tp       <= '0;
      ur       <= '0;
      u        <= '0;
      sat_flag <= 1'b0;
      overrun  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (tick && state != S_IDLE)
        overrun <= 1'b1;
      case (state)
        S_IDLE: if (tick) begin
          cap_tr  <= theta_ref;
          cap_t   <= theta;
          cap_dtr <= dtheta_ref;
          cap_dt  <= dtheta;
          cap_dp  <= dp;
        end
        S_ERR: begin
          e  <= ssub(cap_tr, cap_t);
          de <= ssub(cap_dtr, cap_dt);
        end
        S_MULC:  ce <= mul_q;
        S_SURF: begin
          s  <= sadd(ce, de);
          ss <= clamp(sadd(ce, de), PHI);
        end
        S_MULKS: ts <= mul_q;
        S_MULKP: tp <= mul_q;
        S_SUM:   ur <= ssub(sadd(ts, tp), cap_dp);
        S_CLAMP: begin
          u        <= clamp(ur, UMAX);
          sat_flag <= (ur > UMAX) || (ur < -UMAX);
        end
        // Down-counter: WAIT lasts exactly OBS_LAT cycles.
        S_START: wait_cnt <= CW'(OBS_LAT - 1);
        S_WAIT:  if (wait_cnt != '0) wait_cnt <= wait_cnt - CW'(1);
        default: ;
      endcase
    end
  end

endmodule
